// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, memory-stage FSM states, memory size.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int MEM_BYTES_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage initiator for dataMemory: one bounds-checked load/store per
// request, exactly one memory cycle, response held until consumed.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   ACCESS | single memory cycle, one strobe high
//   RESP   | response valid, held until resp_ready
module mem_access_unit
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [2:0]        resp_stat,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData
);

  // Highest start address whose full quadword still fits in memory.
  localparam logic [ADDR_W-1:0] LAST_LEGAL = ADDR_W'(MEM_BYTES - 8);

  mem_state_t        state_q, state_d;
  logic              req_ready_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic [2:0]        resp_stat_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic [DATA_W-1:0] mem_writeData_d;
  logic              mem_memWrite_d;
  logic              mem_memRead_d;
  logic              addr_legal;

  assign addr_legal = (req_addr <= LAST_LEGAL);

  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready;
    resp_valid_d    = resp_valid;
    resp_rdata_d    = resp_rdata;
    resp_stat_d     = resp_stat;
    mem_address_d   = '0;
    mem_writeData_d = '0;
    mem_memWrite_d  = 1'b0;
    mem_memRead_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          if (addr_legal) begin
            state_d         = ACCESS;
            mem_address_d   = req_addr;
            mem_memWrite_d  = req_write;
            mem_memRead_d   = !req_write;
            mem_writeData_d = req_write ? req_wdata : '0;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_stat_d  = STAT_ADR;
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_stat_d  = STAT_AOK;
        resp_rdata_d = mem_memRead ? mem_readData : '0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_stat     <= STAT_AOK;
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_memWrite  <= 1'b0;
      mem_memRead   <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready     <= req_ready_d;
      resp_valid    <= resp_valid_d;
      resp_rdata    <= resp_rdata_d;
      resp_stat     <= resp_stat_d;
      mem_address   <= mem_address_d;
      mem_writeData <= mem_writeData_d;
      mem_memWrite  <= mem_memWrite_d;
      mem_memRead   <= mem_memRead_d;
    end
  end

endmodule
